// File: rtl/bus16_pkg.sv
// Shared definitions for the 16-bit register bus initiator.
// Data width, FSM encodings and write/read command encoding.
package bus16_pkg;

  localparam int BUS_DATA_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_WAIT_RD = ST_WAIT_RD,
    S_DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/bus16_master_if.sv
// Command/response and register-bus signals of the bus16 initiator.
// master: the initiator's view; slave: the command source and bus slaves.
interface bus16_master_if #(
  parameter int AW = 8
);
  import bus16_pkg::*;

  logic                  i_Cmd_DV;
  logic                  i_Cmd_Wr_Rd_n;
  logic [AW-1:0]         i_Cmd_Addr8;
  logic [BUS_DATA_W-1:0] i_Cmd_Wr_Data;
  logic                  o_Cmd_Ready;
  logic                  o_Rsp_DV;
  logic [BUS_DATA_W-1:0] o_Rsp_Rd_Data;
  logic                  o_Rsp_Timeout;
  logic                  o_Bus_CS;
  logic                  o_Bus_Wr_Rd_n;
  logic [AW-1:0]         o_Bus_Addr8;
  logic [BUS_DATA_W-1:0] o_Bus_Wr_Data;
  logic [BUS_DATA_W-1:0] i_Bus_Rd_Data;
  logic                  i_Bus_Rd_DV;

  modport master (
    input  i_Cmd_DV,
    input  i_Cmd_Wr_Rd_n,
    input  i_Cmd_Addr8,
    input  i_Cmd_Wr_Data,
    output o_Cmd_Ready,
    output o_Rsp_DV,
    output o_Rsp_Rd_Data,
    output o_Rsp_Timeout,
    output o_Bus_CS,
    output o_Bus_Wr_Rd_n,
    output o_Bus_Addr8,
    output o_Bus_Wr_Data,
    input  i_Bus_Rd_Data,
    input  i_Bus_Rd_DV
  );

  modport slave (
    output i_Cmd_DV,
    output i_Cmd_Wr_Rd_n,
    output i_Cmd_Addr8,
    output i_Cmd_Wr_Data,
    input  o_Cmd_Ready,
    input  o_Rsp_DV,
    input  o_Rsp_Rd_Data,
    input  o_Rsp_Timeout,
    input  o_Bus_CS,
    input  o_Bus_Wr_Rd_n,
    input  o_Bus_Addr8,
    input  o_Bus_Wr_Data,
    output i_Bus_Rd_Data,
    output i_Bus_Rd_DV
  );

endinterface

// File: rtl/bus16_master.sv
// Single-outstanding initiator for the 16-bit register bus.
// Issues one CS pulse per command and reports read timeouts.
module bus16_master
  import bus16_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            i_Bus_Clk,
  input  logic            i_Bus_Rst_L,
  bus16_master_if.master  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_nxt;

  logic w_accept;
  logic w_wr_done;
  logic w_rd_hit;
  logic w_to_hit;

  logic                  r_cs;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BUS_DATA_W-1:0] r_wdata;
  logic [BUS_DATA_W-1:0] r_rdata;
  logic                  r_rsp_dv;
  logic                  r_timeout;
  logic [TW-1:0]         r_timer;

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_accept  = 1'b0;
    w_wr_done = 1'b0;
    w_rd_hit  = 1'b0;
    w_to_hit  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_Cmd_DV) begin
          w_accept = 1'b1;
          w_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_wr == CMD_WR) begin
          w_wr_done = 1'b1;
          w_nxt     = S_DONE;
        end else begin
          w_nxt = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        // Data arriving on the terminal cycle beats the timeout.
        if (bus.i_Bus_Rd_DV) begin
          w_rd_hit = 1'b1;
          w_nxt    = S_DONE;
        end else if (r_timer == TERM) begin
          w_to_hit = 1'b1;
          w_nxt    = S_DONE;
        end
      end
      S_DONE: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      r_cs      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rsp_dv  <= 1'b0;
      r_timeout <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_cs     <= w_accept;
      r_rsp_dv <= w_wr_done | w_rd_hit | w_to_hit;
      if (w_accept) begin
        r_wr    <= bus.i_Cmd_Wr_Rd_n;
        r_addr  <= bus.i_Cmd_Addr8;
        r_wdata <= bus.i_Cmd_Wr_Data;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT_RD && r_timer != TERM) begin
        r_timer <= r_timer + TW'(1);
      end
      unique case (1'b1)
        w_wr_done: begin
          r_rdata   <= '0;
          r_timeout <= 1'b0;
        end
        w_rd_hit: begin
          r_rdata   <= bus.i_Bus_Rd_Data;
          r_timeout <= 1'b0;
        end
        w_to_hit: begin
          r_rdata   <= '0;
          r_timeout <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_Cmd_Ready   = (r_state == S_IDLE);
  assign bus.o_Rsp_DV      = r_rsp_dv;
  assign bus.o_Rsp_Rd_Data = r_rdata;
  assign bus.o_Rsp_Timeout = r_timeout;
  assign bus.o_Bus_CS      = r_cs;
  assign bus.o_Bus_Wr_Rd_n = r_wr;
  assign bus.o_Bus_Addr8   = r_addr;
  assign bus.o_Bus_Wr_Data = r_wdata;

endmodule

// File: tb/tb_bus16_master.sv
// Scoreboard bench for bus16_master: reset, write, read, timeout,
// terminal-cycle data, back-to-back commands and mid-transaction reset.
module tb_bus16_master;
  import bus16_pkg::*;

  localparam int TO = 15;

  typedef struct {
    logic [15:0] data;
    logic        to;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus16_master_if #(.AW(8)) bif();

  bus16_master #(
    .ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Bus_Clk(clk),
    .i_Bus_Rst_L(rst_n),
    .bus(bif)
  );

  task automatic issue(input logic wr, input logic [7:0] a,
                       input logic [15:0] d, output int acc);
    @(negedge clk);
    bif.i_Cmd_DV      = 1'b1;
    bif.i_Cmd_Wr_Rd_n = wr;
    bif.i_Cmd_Addr8   = a;
    bif.i_Cmd_Wr_Data = d;
    @(posedge clk);
    #1;
    acc = cyc;
    bif.i_Cmd_DV = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (bif.o_Cmd_Ready !== 1'b1) begin
        errs++;
        $display("FAIL reset_ready cyc=%0d got=%b want=1", i, bif.o_Cmd_Ready);
      end
      checks++;
      if ({bif.o_Rsp_DV, bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout, bif.o_Bus_CS,
           bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data} !== '0) begin
        errs++;
        $display("FAIL reset_outs cyc=%0d dv=%b rd=%h to=%b cs=%b wr=%b a=%h wd=%h want all 0",
                 i, bif.o_Rsp_DV, bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout, bif.o_Bus_CS,
                 bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data);
      end
    end
  endtask

  task automatic test_write();
    int   acc;
    exp_t e;
    bif.i_Bus_Rd_DV   = 1'b1;
    bif.i_Bus_Rd_Data = 16'hFFFF;
    issue(1'b1, 8'h04, 16'hBEEF, acc);
    sb.push_back('{16'h0000, 1'b0, acc + 1});
    checks++;
    if ({bif.o_Bus_CS, bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data, bif.o_Cmd_Ready}
        !== {1'b1, 1'b1, 8'h04, 16'hBEEF, 1'b0}) begin
      errs++;
      $display("FAIL wr_issue cs=%b wr=%b a=%h wd=%h rdy=%b want 1 1 04 beef 0",
               bif.o_Bus_CS, bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data,
               bif.o_Cmd_Ready);
    end
    @(negedge clk);
    checks++;
    if ({bif.o_Bus_CS, bif.o_Rsp_DV} !== 2'b10) begin
      errs++;
      $display("FAIL wr_cs_hold cs=%b dv=%b want cs=1 dv=0", bif.o_Bus_CS, bif.o_Rsp_DV);
    end
    @(negedge clk);
    checks++;
    if ({bif.o_Bus_CS, bif.o_Rsp_DV} !== 2'b01) begin
      errs++;
      $display("FAIL wr_done cs=%b dv=%b want cs=0 dv=1", bif.o_Bus_CS, bif.o_Rsp_DV);
    end
    e = sb.pop_front();
    checks++;
    if ({bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout} !== {e.data, e.to} || cyc != e.cyc) begin
      errs++;
      $display("FAIL wr_rsp data=%h to=%b cyc=%0d want %h %b %0d",
               bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout, cyc, e.data, e.to, e.cyc);
    end
    @(negedge clk);
    bif.i_Bus_Rd_DV = 1'b0;
    checks++;
    if ({bif.o_Rsp_DV, bif.o_Cmd_Ready, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data}
        !== {1'b0, 1'b1, 8'h04, 16'hBEEF}) begin
      errs++;
      $display("FAIL wr_after dv=%b rdy=%b a=%h wd=%h want 0 1 04 beef",
               bif.o_Rsp_DV, bif.o_Cmd_Ready, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data);
    end
  endtask

  task automatic test_read();
    int   acc;
    exp_t e;
    issue(1'b0, 8'h02, 16'h0000, acc);
    sb.push_back('{16'h1234, 1'b0, acc + 2});
    checks++;
    if ({bif.o_Bus_CS, bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8} !== {1'b1, 1'b0, 8'h02}) begin
      errs++;
      $display("FAIL rd_issue cs=%b wr=%b a=%h want 1 0 02",
               bif.o_Bus_CS, bif.o_Bus_Wr_Rd_n, bif.o_Bus_Addr8);
    end
    @(negedge clk);
    @(negedge clk);
    bif.i_Bus_Rd_DV   = 1'b1;
    bif.i_Bus_Rd_Data = 16'h1234;
    checks++;
    if ({bif.o_Bus_CS, bif.o_Rsp_DV} !== 2'b00) begin
      errs++;
      $display("FAIL rd_wait cs=%b dv=%b want 0 0", bif.o_Bus_CS, bif.o_Rsp_DV);
    end
    @(negedge clk);
    bif.i_Bus_Rd_DV   = 1'b0;
    bif.i_Bus_Rd_Data = 16'h0000;
    checks++;
    if (bif.o_Rsp_DV !== 1'b1) begin
      errs++;
      $display("FAIL rd_dv got=%b want=1 cyc=%0d", bif.o_Rsp_DV, cyc);
    end
    e = sb.pop_front();
    checks++;
    if ({bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout} !== {e.data, e.to} || cyc != e.cyc) begin
      errs++;
      $display("FAIL rd_rsp data=%h to=%b cyc=%0d want %h %b %0d",
               bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout, cyc, e.data, e.to, e.cyc);
    end
  endtask

  task automatic test_timeout();
    int   acc;
    bit   got;
    exp_t e;
    issue(1'b0, 8'h10, 16'h0000, acc);
    sb.push_back('{16'h0000, 1'b1, acc + TO + 1});
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bif.o_Rsp_DV === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errs++;
      $display("FAIL to_wait no Rsp_DV within 40 cycles, want at cyc %0d", e.cyc);
    end else if ({bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout} !== {e.data, e.to} ||
                 cyc != e.cyc) begin
      errs++;
      $display("FAIL to_rsp data=%h to=%b cyc=%0d want %h %b %0d",
               bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout, cyc, e.data, e.to, e.cyc);
    end
  endtask

  task automatic test_terminal();
    int   acc;
    bit   early;
    exp_t e;
    bif.i_Bus_Rd_DV   = 1'b1;
    bif.i_Bus_Rd_Data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bif.o_Rsp_DV, bif.o_Cmd_Ready} !== 2'b01) begin
        errs++;
        $display("FAIL stray_idle dv=%b rdy=%b want 0 1", bif.o_Rsp_DV, bif.o_Cmd_Ready);
      end
    end
    bif.i_Bus_Rd_DV = 1'b0;
    issue(1'b0, 8'h20, 16'h0000, acc);
    sb.push_back('{16'h5A5A, 1'b0, acc + TO + 1});
    early = 1'b0;
    for (int k = 0; k < 40 && cyc < acc + TO; k++) begin
      @(negedge clk);
      if (bif.o_Rsp_DV === 1'b1) early = 1'b1;
    end
    checks++;
    if (early || cyc != acc + TO) begin
      errs++;
      $display("FAIL term_wait early=%b cyc=%0d want early=0 cyc=%0d", early, cyc, acc + TO);
    end
    bif.i_Bus_Rd_DV   = 1'b1;
    bif.i_Bus_Rd_Data = 16'h5A5A;
    @(negedge clk);
    bif.i_Bus_Rd_DV   = 1'b0;
    bif.i_Bus_Rd_Data = 16'h0000;
    e = sb.pop_front();
    checks++;
    if ({bif.o_Rsp_DV, bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout} !== {1'b1, e.data, e.to} ||
        cyc != e.cyc) begin
      errs++;
      $display("FAIL term_rsp dv=%b data=%h to=%b cyc=%0d want 1 %h %b %0d",
               bif.o_Rsp_DV, bif.o_Rsp_Rd_Data, bif.o_Rsp_Timeout, cyc, e.data, e.to, e.cyc);
    end
  endtask

  task automatic test_back_to_back();
    int   acc;
    int   n;
    bit   got;
    exp_t e;
    @(negedge clk);
    bif.i_Cmd_DV      = 1'b1;
    bif.i_Cmd_Wr_Rd_n = 1'b1;
    bif.i_Cmd_Addr8   = 8'h30;
    bif.i_Cmd_Wr_Data = 16'h1111;
    @(posedge clk);
    #1;
    acc = cyc;
    bif.i_Cmd_Addr8   = 8'h31;
    bif.i_Cmd_Wr_Data = 16'h2222;
    sb.push_back('{16'h0000, 1'b0, acc + 1});
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bif.o_Rsp_DV === 1'b1) begin
        n++;
        e = sb.pop_front();
        checks++;
        if (cyc != e.cyc || bif.o_Rsp_Timeout !== e.to) begin
          errs++;
          $display("FAIL b2b_rsp1 cyc=%0d to=%b want %0d %b", cyc, bif.o_Rsp_Timeout,
                   e.cyc, e.to);
        end
      end
      if (bif.o_Bus_CS === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    bif.i_Cmd_DV = 1'b0;
    checks++;
    if (!got || n != 1 || cyc != acc + 3 || bif.o_Bus_Addr8 !== 8'h31) begin
      errs++;
      $display("FAIL b2b_accept got=%b rsp=%0d cyc=%0d a=%h want 1 1 %0d 31",
               got, n, cyc, bif.o_Bus_Addr8, acc + 3);
    end
    sb.push_back('{16'h0000, 1'b0, acc + 4});
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bif.o_Rsp_DV === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!got || cyc != e.cyc || bif.o_Bus_Wr_Data !== 16'h2222) begin
      errs++;
      $display("FAIL b2b_rsp2 got=%b cyc=%0d wd=%h want 1 %0d 2222",
               got, cyc, bif.o_Bus_Wr_Data, e.cyc);
    end
  endtask

  task automatic test_reset_mid();
    int   acc;
    bit   dv_seen;
    bit   got;
    exp_t e;
    issue(1'b0, 8'h40, 16'h0000, acc);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.o_Bus_CS, bif.o_Cmd_Ready} !== 2'b01) begin
      errs++;
      $display("FAIL rst_issue cs=%b rdy=%b want 0 1", bif.o_Bus_CS, bif.o_Cmd_Ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 8'h44, 16'h0000, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.o_Bus_CS, bif.o_Cmd_Ready, bif.o_Rsp_DV} !== 3'b010) begin
      errs++;
      $display("FAIL rst_wait cs=%b rdy=%b dv=%b want 0 1 0",
               bif.o_Bus_CS, bif.o_Cmd_Ready, bif.o_Rsp_DV);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dv_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.o_Rsp_DV !== 1'b0) dv_seen = 1'b1;
    end
    checks++;
    if (dv_seen) begin
      errs++;
      $display("FAIL rst_no_rsp got Rsp_DV after reset want none");
    end
    issue(1'b1, 8'h50, 16'hABCD, acc);
    sb.push_back('{16'h0000, 1'b0, acc + 1});
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bif.o_Rsp_DV === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!got || cyc != e.cyc || bif.o_Rsp_Timeout !== e.to ||
        {bif.o_Bus_Addr8, bif.o_Bus_Wr_Data} !== {8'h50, 16'hABCD}) begin
      errs++;
      $display("FAIL rst_post_wr got=%b cyc=%0d to=%b a=%h wd=%h want 1 %0d %b 50 abcd",
               got, cyc, bif.o_Rsp_Timeout, bif.o_Bus_Addr8, bif.o_Bus_Wr_Data, e.cyc, e.to);
    end
  endtask

  initial begin
    bif.i_Cmd_DV      = 1'b0;
    bif.i_Cmd_Wr_Rd_n = 1'b0;
    bif.i_Cmd_Addr8   = 8'h00;
    bif.i_Cmd_Wr_Data = 16'h0000;
    bif.i_Bus_Rd_Data = 16'h0000;
    bif.i_Bus_Rd_DV   = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_terminal();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
